// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit adder slice and a carry register reused once per nibble.
// SUM/Cout/OVF are loaded only on the final nibble, so they never show partial results.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  input  logic                 C0,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] SUM,
  output logic                 Cout,
  output logic                 OVF
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_step;
  logic             w_last;

  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_acc;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;

  logic [W-1:0]     r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [5:0]       w_slice;
  logic [3:0]       w_slice_sum;
  logic             w_c3;
  logic             w_c4;
  logic [W-1:0]     w_acc_nxt;

  // Returns {carry out of bit 3, carry into bit 3, 4-bit sum}; the carry into
  // bit 3 is kept so the top nibble can produce the signed-overflow flag.
  function automatic logic [5:0] add_slice(input logic [3:0] a,
                                           input logic [3:0] b,
                                           input logic       cin);
    logic [3:0] lo;
    logic [1:0] hi;
    lo = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, cin};
    hi = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, lo[3]};
    return {hi[1], lo[3], hi[0], lo[2:0]};
  endfunction

  // Slice operand select and result-nibble merge
  always_comb begin
    int unsigned lsb;
    lsb         = 4 * int'(r_idx);
    w_a_nib     = r_a[lsb +: 4];
    w_b_nib     = r_b[lsb +: 4];
    w_slice     = add_slice(w_a_nib, w_b_nib, r_carry);
    w_slice_sum = w_slice[3:0];
    w_c3        = w_slice[4];
    w_c4        = w_slice[5];
    w_acc_nxt   = r_acc;
    w_acc_nxt[lsb +: 4] = w_slice_sum;
  end

  assign w_last = (r_idx == IDX_W'(NIBBLES - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control and result registers (asynchronously cleared)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_carry <= C0;
        r_idx   <= '0;
      end else if (w_step) begin
        r_carry <= w_c4;
        r_idx   <= r_idx + IDX_W'(1);
        if (w_last) begin
          r_sum  <= w_acc_nxt;
          r_cout <= w_c4;
          r_ovf  <= w_c3 ^ w_c4;
        end
      end
    end
  end

  // Operand and partial-result registers need no reset: they are always
  // rewritten before they are read
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= A;
      r_b <= B;
    end
    if (w_step) r_acc <= w_acc_nxt;
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign SUM  = r_sum;
  assign Cout = r_cout;
  assign OVF  = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (NIBBLES=4): vector table plus
// hand-written sequences for start-while-busy, reset abort and back-to-back starts.
module tb_nibble_serial_adder;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         C0;
  logic         busy;
  logic         done;
  logic [W-1:0] SUM;
  logic         Cout;
  logic         OVF;

  int n_cmp;
  int n_err;
  logic [W-1:0] prev_sum;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[7];

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .C0    (C0),
    .busy  (busy),
    .done  (done),
    .SUM   (SUM),
    .Cout  (Cout),
    .OVF   (OVF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One complete operation; entered and left with the DUT idle
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c0,
                        input logic [W-1:0] es, input logic ec, input logic eo,
                        input string nm);
    @(negedge clk);
    start = 1'b1; A = a; B = b; C0 = c0;
    @(negedge clk);
    start = 1'b0; A = ~a; B = W'($urandom); C0 = ~c0;
    chkb({nm, " busy"}, busy, 1'b1);
    for (int j = 1; j < N; j++) begin
      @(negedge clk);
      chkb({nm, " early done"}, done, 1'b0);
    end
    chkw({nm, " SUM held in RUN"}, SUM, prev_sum);
    @(negedge clk);
    chkb({nm, " done"}, done, 1'b1);
    chkw({nm, " SUM"}, SUM, es);
    chkb({nm, " Cout"}, Cout, ec);
    chkb({nm, " OVF"}, OVF, eo);
    @(negedge clk);
    chkb({nm, " done width"}, done, 1'b0);
    chkb({nm, " busy idle"}, busy, 1'b0);
    prev_sum = es;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    prev_sum = '0;
    vecs[0] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'h1234, 16'h5678, 1'b0, 16'h68AC, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'h8001, 1'b0, 16'h0001, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; A = '0; B = '0; C0 = 1'b0;
    #1;
    chkb("reset busy", busy, 1'b0);
    chkb("reset done", done, 1'b0);
    chkw("reset SUM", SUM, 16'h0000);
    chkb("reset Cout", Cout, 1'b0);
    chkb("reset OVF", OVF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].c0, vecs[i].sum, vecs[i].cout, vecs[i].ovf,
             $sformatf("vec%0d", i));

    // Reset in the middle of RUN aborts without a done pulse
    @(negedge clk);
    start = 1'b1; A = 16'hFFFF; B = 16'hFFFF; C0 = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chkb("abort pre busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chkb("abort busy", busy, 1'b0);
    chkb("abort done", done, 1'b0);
    chkw("abort SUM", SUM, 16'h0000);
    chkb("abort Cout", Cout, 1'b0);
    chkb("abort OVF", OVF, 1'b0);
    start = 1'b1; A = 16'h1111; B = 16'h2222; C0 = 1'b0;
    @(negedge clk);
    chkb("start in rst busy", busy, 1'b0);
    chkb("start in rst done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chkb("post rst busy", busy, 1'b0);
    prev_sum = '0;
    run_op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, "after rst");

    // start held through RUN and DONE must not launch a second operation
    @(negedge clk);
    start = 1'b1; A = 16'h1234; B = 16'h1111; C0 = 1'b0;
    @(negedge clk);
    A = 16'hFFFF; B = 16'hFFFF;
    for (int j = 1; j < N; j++) begin
      @(negedge clk);
      chkb("busy-start early done", done, 1'b0);
    end
    @(negedge clk);
    chkb("busy-start done", done, 1'b1);
    chkw("busy-start SUM", SUM, 16'h2345);
    @(negedge clk);
    start = 1'b0;
    chkb("busy-start idle busy", busy, 1'b0);
    chkb("busy-start single done", done, 1'b0);
    @(negedge clk);
    chkb("busy-start no relaunch", busy, 1'b0);
    chkw("busy-start SUM kept", SUM, 16'h2345);

    // start held continuously: one op every N+2 cycles
    @(negedge clk);
    start = 1'b1; A = 16'h0101; B = 16'h0202; C0 = 1'b0;
    for (int j = 0; j < 3 * (N + 2); j++) begin
      int m;
      @(negedge clk);
      m = j % (N + 2);
      chkb($sformatf("b2b busy c%0d", j), busy, (m != N + 1));
      chkb($sformatf("b2b done c%0d", j), done, (m == N));
      if (m == N) chkw($sformatf("b2b SUM c%0d", j), SUM, 16'h0303);
    end
    start = 1'b0;
    repeat (N + 3) @(negedge clk);
    chkb("final idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
